add_multicycle: RTL and testbench
=================================

Name: add_multicycle

Overview:
- Sequential wide adder that computes {CO,S} = A+B+CI on words*width-bit operands.
- Reuses one AddCfast instance of chunk width `width`, one chunk per cycle, least-significant chunk first.
- The carry is registered between chunks and fed into the AddCfast fast carry-in.
- Sits upstream of AddCfast and drives its operands. Used where a full-width single-cycle adder misses area or timing budget.

Parameters:
width, 8, chunk width in bits; the AddCfast instance width.
words, 4, number of chunks; operand width is words*width; legal range >= 1.
speed, 0, passed unchanged to the AddCfast instance (0 serial, 1 Brent-Kung, 2 Sklansky).

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_ni  input  1  reset; asynchronous, active-low.
in_valid_i  input  1  operand request valid.
in_ready_o  output  1  block accepts operands.
A  input  words*width  operand A.
B  input  words*width  operand B.
CI  input  1  carry in.
out_valid_o  output  1  result valid.
out_ready_i  input  1  downstream accepts result.
S  output  words*width  sum.
CO  output  1  carry out.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state=IDLE, chunk index=0, carry register=0.
  - Operand registers=0, S=0, CO=0, out_valid_o=0.
  - in_ready_o=1 (decoded from IDLE).
- State machine states: IDLE, RUN, DONE. in_ready_o = (state==IDLE); out_valid_o = (state==DONE). Both are decoded from registered state only.
- IDLE: on in_valid_i && in_ready_o:
  - Latch A, B into operand registers.
  - carry register <= CI, index <= 0, state <= RUN.
  - Inputs are not sampled at any other time; changes to A/B/CI after acceptance have no effect.
- RUN, each cycle:
  - The AddCfast instance gets chunk[index] of the latched A and B, with CI = carry register.
  - S chunk[index] <= instance sum; carry register <= instance CO.
  - If index==words-1: CO <= instance CO, state <= DONE. Otherwise index++.
- Latency: acceptance at edge t gives out_valid_o=1 after edge t+words. words=1 gives a 1-cycle RUN.
- DONE:
  - S and CO are held stable while out_valid_o=1.
  - On out_ready_i: state <= IDLE. out_valid_o drops and in_ready_o rises after that edge.
  - A new request is accepted at the earliest one cycle after the handshake, so steady-state throughput is one result per words+2 cycles.
- S chunks above the current index keep their previous values during RUN. S is only defined while out_valid_o=1.
- Arithmetic:
  - Result is exact modulo 2^(words*width), with CO as bit words*width.
  - All-ones operands with CI=1 give S=all-ones, CO=1.
  - Chunk carries propagate only through the carry register, never combinationally across chunks.
- Reset mid-operation (RUN or DONE): the operation is aborted, all registers return to reset values, and no result is presented.
- in_valid_i during RUN/DONE: ignored (in_ready_o=0). The requester must hold the request.
- out_ready_i while out_valid_o=0: ignored.
- Index counter width: $clog2(words), minimum 1 bit.

Test Plan:
1. width=8, words=4, A=0x000000FF, B=0x00000001, CI=0, out_ready_i=1 -> out_valid_o exactly 4 cycles after acceptance, S=0x00000100, CO=0; in_ready_o=1 the cycle after the handshake.
2. A=0xFFFFFFFF, B=0x00000000, CI=1 -> S=0x00000000, CO=1 (carry ripples through all 4 chunks). Then A=0x80000000, B=0x80000000, CI=0 -> S=0, CO=1.
3. Backpressure: out_ready_i=0 for 5 cycles after out_valid_o -> S and CO stable, in_ready_o=0, a new in_valid_i is not accepted. out_ready_i=1 -> IDLE next cycle.
4. Reset mid-RUN: assert rst_ni=0 at RUN index 2 (asynchronous, between edges) -> out_valid_o=0, S=0, CO=0, in_ready_o=1 immediately. Next request A=0x12345678, B=0x11111111, CI=1 -> S=0x2345678A, CO=0.
5. Input change after acceptance: change A to 0xDEADBEEF one cycle after acceptance of A=1, B=1, CI=0 -> S=0x00000002.
6. Random regression: 10k operations with random valid/ready stalls, for words in {1,3,4} and speed in {0,1,2} -> every {CO,S} equals A+B+CI from the behavioural model, with no lost or duplicated results.

Source files
------------

// File: rtl/add_multicycle.sv
// Chunk-serial wide adder: one AddCfast slice reused per cycle,
// carry held in a register between chunks, LS chunk first.

module AddCfast #(
    parameter int width = 8,
    parameter int speed = 0
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             CI,
    output logic [width-1:0] S,
    output logic             CO
);
    localparam int lv = (width > 1) ? $clog2(width) : 1;

    logic [width-1:0] gg, pp, gn, pn;
    logic [width:0]   c;

    // gg/pp become group generate/propagate over bits [0..i]
    always_comb begin
        gg = A & B;
        pp = A ^ B;
        gn = gg;
        pn = pp;
        c  = '0;
        c[0] = CI;
        if (speed == 0) begin
            for (int i = 0; i < width; i++)
                c[i+1] = gg[i] | (pp[i] & c[i]);
        end else begin
            if (speed == 2) begin
                for (int l = 0; l < lv; l++) begin
                    gn = gg;
                    pn = pp;
                    for (int i = 0; i < width; i++) begin
                        if (((i >> l) & 1) == 1) begin
                            gn[i] = gg[i] | (pp[i] & gg[((i >> l) << l) - 1]);
                            pn[i] = pp[i] & pp[((i >> l) << l) - 1];
                        end
                    end
                    gg = gn;
                    pp = pn;
                end
            end else begin
                for (int l = 0; l < lv; l++) begin
                    gn = gg;
                    pn = pp;
                    for (int i = 0; i < width; i++) begin
                        if (((i + 1) % (2 << l)) == 0) begin
                            gn[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                            pn[i] = pp[i] & pp[i - (1 << l)];
                        end
                    end
                    gg = gn;
                    pp = pn;
                end
                for (int l = lv - 2; l >= 0; l--) begin
                    gn = gg;
                    pn = pp;
                    for (int i = 0; i < width; i++) begin
                        if (((i + 1) % (2 << l)) == (1 << l) && i >= (2 << l)) begin
                            gn[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                            pn[i] = pp[i] & pp[i - (1 << l)];
                        end
                    end
                    gg = gn;
                    pp = pn;
                end
            end
            for (int i = 0; i < width; i++)
                c[i+1] = gg[i] | (pp[i] & CI);
        end
        S  = A ^ B ^ c[width-1:0];
        CO = c[width];
    end
endmodule

module add_multicycle #(
    parameter int width = 8,
    parameter int words = 4,
    parameter int speed = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [words*width-1:0] A,
    input  logic [words*width-1:0] B,
    input  logic                   CI,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [words*width-1:0] S,
    output logic                   CO
);
    localparam int iw = (words > 1) ? $clog2(words) : 1;
    localparam int n  = words * width;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_d;
    logic [iw-1:0]   idx;
    logic            carry;
    logic [n-1:0]    a_q, b_q;
    logic [width-1:0] a_c, b_c, s_c;
    logic            co_c;
    logic            last;

    assign a_c  = a_q[int'(idx)*width +: width];
    assign b_c  = b_q[int'(idx)*width +: width];
    assign last = (idx == iw'(words - 1));

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);

    AddCfast #(.width(width), .speed(speed)) u_add (
        .A  (a_c),
        .B  (b_c),
        .CI (carry),
        .S  (s_c),
        .CO (co_c)
    );

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (in_valid_i) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            S     <= '0;
            CO    <= 1'b0;
        end else begin
            state <= state_d;
            unique case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q   <= A;
                        b_q   <= B;
                        carry <= CI;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    S[int'(idx)*width +: width] <= s_c;
                    carry <= co_c;
                    if (last) CO <= co_c;
                    else idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_add_multicycle.sv
// Bench for add_multicycle: directed table and corner sequences on a
// 4x8 instance, plus random traffic on nine words/speed variants.

module tb_add_multicycle;
    localparam int OPS = 1112;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic        rst_n, iv, ir, ov, ordy, ci, co;
    logic [31:0] a, b, s;

    add_multicycle #(.width(8), .words(4), .speed(0)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (iv),
        .in_ready_o  (ir),
        .A           (a),
        .B           (b),
        .CI          (ci),
        .out_valid_o (ov),
        .out_ready_i (ordy),
        .S           (s),
        .CO          (co)
    );

    logic       rrst_n;
    logic [8:0] rdone;

    for (genvar k = 0; k < 9; k++) begin : g
        localparam int W   = (k / 3 == 0) ? 1 : (k / 3 == 1) ? 3 : 4;
        localparam int SPD = k % 3;
        localparam int N   = 8 * W;

        logic         riv, rir, rov, rordy, rci, rco, pend;
        logic [N-1:0] ra, rb, rs;
        logic [N:0]   q[$];
        logic [N:0]   e;
        int           sent, got, cyc;

        add_multicycle #(.width(8), .words(W), .speed(SPD)) rdut (
            .clk_i       (clk),
            .rst_ni      (rrst_n),
            .in_valid_i  (riv),
            .in_ready_o  (rir),
            .A           (ra),
            .B           (rb),
            .CI          (rci),
            .out_valid_o (rov),
            .out_ready_i (rordy),
            .S           (rs),
            .CO          (rco)
        );

        initial begin
            rdone[k] = 1'b0;
            riv = 0; rordy = 0; ra = '0; rb = '0; rci = 0; pend = 0;
            sent = 0; got = 0; cyc = 0;
            @(posedge rrst_n);
            while (got < OPS && cyc < 30000) begin
                @(negedge clk);
                cyc++;
                if (!pend && sent < OPS && $urandom_range(3) != 0) begin
                    ra = ($urandom_range(7) == 0) ? '1 : N'($urandom);
                    rb = ($urandom_range(7) == 0) ? '1 : N'($urandom);
                    rci = 1'($urandom);
                    pend = 1;
                end
                riv = pend;
                rordy = ($urandom_range(3) != 0);
                if (riv && rir) begin
                    q.push_back({1'b0, ra} + {1'b0, rb} + (N+1)'(rci));
                    sent++;
                    pend = 0;
                end
                if (rov && rordy) begin
                    if (q.size() == 0) begin
                        chk($sformatf("rand_dup_w%0d_s%0d", W, SPD), 64'(got), 64'(sent));
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("rand_sum_w%0d_s%0d", W, SPD), 64'({rco, rs}), 64'(e));
                    end
                    got++;
                end
            end
            chk($sformatf("rand_count_w%0d_s%0d", W, SPD), 64'(got), 64'(OPS));
            chk($sformatf("rand_left_w%0d_s%0d", W, SPD), 64'(q.size()), 64'(0));
            riv = 0;
            rdone[k] = 1'b1;
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        co;
    } vec_t;

    vec_t tv[8];
    int   lat;

    task automatic do_op(input logic [31:0] va, input logic [31:0] vb,
                         input logic vci, input logic [31:0] alate,
                         output int latency);
        int w;
        @(negedge clk);
        a = va; b = vb; ci = vci; iv = 1; ordy = 0;
        w = 0;
        while (!ir && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        iv = 0;
        latency = 0;
        @(posedge clk);
        #1;
        a = alate;
        b = ~vb;
        ci = ~vci;
        latency = 1;
        while (!ov && latency < 50) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        ordy = 1;
        @(posedge clk);
        #1;
        ordy = 0;
    endtask

    initial begin
        tv[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
        tv[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        tv[2] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        tv[3] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0};
        tv[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        tv[5] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        tv[6] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0};
        tv[7] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};

        rst_n = 0; rrst_n = 0;
        iv = 0; ordy = 0; a = '0; b = '0; ci = 0;
        #2;
        chk("reset_ready", 64'(ir), 64'(1));
        chk("reset_valid", 64'(ov), 64'(0));
        chk("reset_s", 64'(s), 64'(0));
        chk("reset_co", 64'(co), 64'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1; rrst_n = 1;

        for (int i = 0; i < 8; i++) begin
            do_op(tv[i].a, tv[i].b, tv[i].ci, tv[i].a, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(4));
            chk($sformatf("vec%0d_s", i), 64'(s), 64'(tv[i].s));
            chk($sformatf("vec%0d_co", i), 64'(co), 64'(tv[i].co));
            release_out();
            chk($sformatf("vec%0d_ready_after", i), 64'(ir), 64'(1));
            chk($sformatf("vec%0d_valid_after", i), 64'(ov), 64'(0));
        end

        do_op(32'h0000FFFF, 32'h00000001, 1'b0, 32'h0000FFFF, lat);
        @(negedge clk);
        a = 32'h55555555; b = 32'h11111111; iv = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_s", 64'(s), 64'h00010000);
            chk("bp_co", 64'(co), 64'(0));
            chk("bp_valid", 64'(ov), 64'(1));
            chk("bp_ready", 64'(ir), 64'(0));
        end
        @(negedge clk);
        iv = 0; ordy = 1;
        @(posedge clk);
        #1;
        ordy = 0;
        chk("bp_release_ready", 64'(ir), 64'(1));
        chk("bp_release_valid", 64'(ov), 64'(0));

        @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'h00000001; ci = 0; iv = 1;
        @(posedge clk);
        #1;
        iv = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("rst_mid_valid", 64'(ov), 64'(0));
        chk("rst_mid_ready", 64'(ir), 64'(1));
        chk("rst_mid_s", 64'(s), 64'(0));
        chk("rst_mid_co", 64'(co), 64'(0));
        @(negedge clk);
        rst_n = 1;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_result", 64'(ov), 64'(0));
        do_op(32'h12345678, 32'h11111111, 1'b1, 32'h12345678, lat);
        chk("after_rst_s", 64'(s), 64'h2345678A);
        chk("after_rst_co", 64'(co), 64'(0));
        release_out();

        do_op(32'h00000001, 32'h00000001, 1'b0, 32'hDEADBEEF, lat);
        chk("late_change_s", 64'(s), 64'h00000002);
        chk("late_change_co", 64'(co), 64'(0));
        release_out();

        lat = 0;
        while (rdone != 9'h1FF && lat < 60000) begin
            @(posedge clk);
            lat++;
        end
        chk("rand_all_done", 64'(rdone), 64'h1FF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
